// File: rtl/usr_c2h0_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : usr_c2h0_pkt_fifo
// Purpose  : Store-and-forward packet FIFO feeding the DMA C2H0 AXI-Stream port.
// Revision : 1.0  initial release
// ============================================================================
module usr_c2h0_pkt_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = 16,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  usr_clk,
  input  logic                  usr_rst_n,
  input  logic                  s0_axis_c2h_rst_i,
  input  logic [DATA_WIDTH-1:0] in_tdata_i,
  input  logic [KEEP_WIDTH-1:0] in_tkeep_i,
  input  logic [KEEP_WIDTH-1:0] in_tuser_i,
  input  logic                  in_tlast_i,
  input  logic                  in_tvalid_i,
  output logic                  in_tready_o,
  output logic [DATA_WIDTH-1:0] s0_axis_c2h_tdata_o,
  output logic [KEEP_WIDTH-1:0] s0_axis_c2h_tkeep_o,
  output logic [KEEP_WIDTH-1:0] s0_axis_c2h_tuser_o,
  output logic                  s0_axis_c2h_tlast_o,
  output logic                  s0_axis_c2h_tvalid_o,
  input  logic                  s0_axis_c2h_tready_i,
  output logic [DEPTH_LOG2:0]   fill_lvl_o,
  output logic [DEPTH_LOG2:0]   pkt_cnt_o,
  output logic                  ovf_err_o
);

  localparam int                    MEM_WIDTH = DATA_WIDTH + 2 * KEEP_WIDTH;
  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LVL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [MEM_WIDTH-1:0]  mem      [DEPTH];
  logic                  last_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   rd_pkts;
  logic                  flush;
  logic                  wr_en;
  logic                  wr_last;
  logic                  rd_en;
  logic                  rd_last;
  logic                  out_hs;
  logic                  out_last_hs;

  assign flush       = s0_axis_c2h_rst_i;
  assign in_tready_o = (fill_lvl_o < FULL_LVL) & ~flush;
  assign wr_en       = in_tvalid_i & in_tready_o;
  assign wr_last     = wr_en & in_tlast_i;
  assign out_hs      = s0_axis_c2h_tvalid_o & s0_axis_c2h_tready_i;
  assign out_last_hs = out_hs & s0_axis_c2h_tlast_o;

  // rd_pkts counts tlast beats still in RAM; while non-zero the beat at rd_ptr
  // belongs to a packet whose tlast is already stored, so it may be released.
  assign rd_en   = (rd_pkts != '0) & (~s0_axis_c2h_tvalid_o | s0_axis_c2h_tready_i) & ~flush;
  assign rd_last = rd_en & last_mem[rd_ptr];

  always_ff @(posedge usr_clk) begin
    if (wr_en) begin
      mem[wr_ptr]      <= {in_tdata_i, in_tkeep_i, in_tuser_i};
      last_mem[wr_ptr] <= in_tlast_i;
    end
  end

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_lvl_o <= '0;
      pkt_cnt_o  <= '0;
      rd_pkts    <= '0;
      ovf_err_o  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_lvl_o <= '0;
      pkt_cnt_o  <= '0;
      rd_pkts    <= '0;
      ovf_err_o  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end

      case ({wr_en, out_hs})
        2'b10:   fill_lvl_o <= fill_lvl_o + CNT_ONE;
        2'b01:   fill_lvl_o <= fill_lvl_o - CNT_ONE;
        default: ;
      endcase

      case ({wr_last, out_last_hs})
        2'b10:   pkt_cnt_o <= pkt_cnt_o + CNT_ONE;
        2'b01:   pkt_cnt_o <= pkt_cnt_o - CNT_ONE;
        default: ;
      endcase

      case ({wr_last, rd_last})
        2'b10:   rd_pkts <= rd_pkts + CNT_ONE;
        2'b01:   rd_pkts <= rd_pkts - CNT_ONE;
        default: ;
      endcase

      // Full with no complete packet can never drain: latch it for software.
      if ((fill_lvl_o == FULL_LVL) && (pkt_cnt_o == '0)) begin
        ovf_err_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge usr_clk or negedge usr_rst_n) begin
    if (!usr_rst_n) begin
      s0_axis_c2h_tdata_o  <= '0;
      s0_axis_c2h_tkeep_o  <= '0;
      s0_axis_c2h_tuser_o  <= '0;
      s0_axis_c2h_tlast_o  <= 1'b0;
      s0_axis_c2h_tvalid_o <= 1'b0;
    end else if (flush) begin
      s0_axis_c2h_tdata_o  <= '0;
      s0_axis_c2h_tkeep_o  <= '0;
      s0_axis_c2h_tuser_o  <= '0;
      s0_axis_c2h_tlast_o  <= 1'b0;
      s0_axis_c2h_tvalid_o <= 1'b0;
    end else if (rd_en) begin
      {s0_axis_c2h_tdata_o, s0_axis_c2h_tkeep_o, s0_axis_c2h_tuser_o} <= mem[rd_ptr];
      s0_axis_c2h_tlast_o  <= last_mem[rd_ptr];
      s0_axis_c2h_tvalid_o <= 1'b1;
    end else if (s0_axis_c2h_tready_i) begin
      s0_axis_c2h_tvalid_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usr_c2h0_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_usr_c2h0_pkt_fifo
// Purpose  : Randomised self-checking bench for the C2H0 packet FIFO.
// Revision : 1.0  initial release
// ============================================================================
module tb_usr_c2h0_pkt_fifo;

  localparam int DW    = 128;
  localparam int KW    = 16;
  localparam int DL    = 9;
  localparam int DEPTH = 512;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [KW-1:0] u;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] in_tdata;
  logic [KW-1:0] in_tkeep;
  logic [KW-1:0] in_tuser;
  logic          in_tlast;
  logic          in_tvalid;
  logic          in_tready;
  logic [DW-1:0] out_tdata;
  logic [KW-1:0] out_tkeep;
  logic [KW-1:0] out_tuser;
  logic          out_tlast;
  logic          out_tvalid;
  logic          out_tready;
  logic [DL:0]   fill_lvl;
  logic [DL:0]   pkt_cnt;
  logic          ovf_err;

  usr_c2h0_pkt_fifo #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH_LOG2(DL)) dut (
    .usr_clk              (clk),
    .usr_rst_n            (rst_n),
    .s0_axis_c2h_rst_i    (flush),
    .in_tdata_i           (in_tdata),
    .in_tkeep_i           (in_tkeep),
    .in_tuser_i           (in_tuser),
    .in_tlast_i           (in_tlast),
    .in_tvalid_i          (in_tvalid),
    .in_tready_o          (in_tready),
    .s0_axis_c2h_tdata_o  (out_tdata),
    .s0_axis_c2h_tkeep_o  (out_tkeep),
    .s0_axis_c2h_tuser_o  (out_tuser),
    .s0_axis_c2h_tlast_o  (out_tlast),
    .s0_axis_c2h_tvalid_o (out_tvalid),
    .s0_axis_c2h_tready_i (out_tready),
    .fill_lvl_o           (fill_lvl),
    .pkt_cnt_o            (pkt_cnt),
    .ovf_err_o            (ovf_err)
  );

  always #5 clk = ~clk;

  beat_t out_b;
  beat_t in_b;
  assign out_b = {out_tdata, out_tkeep, out_tuser, out_tlast};
  assign in_b  = {in_tdata, in_tkeep, in_tuser, in_tlast};

  // Reference model: every accepted beat in order, plus packet/overflow state
  beat_t exp_q[$];
  int    m_pkts = 0;
  logic  m_ovf  = 1'b0;

  int    n_cmp = 0;
  int    n_err = 0;
  int    tick_no = 0;
  logic  wr, rd, prev_hold, prev_mid, rnd_ready;
  beat_t prev_beat;
  int    first_valid, last_wr, first_hs, last_hs, hs_cnt;

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_stats();
    first_valid = -1;
    last_wr     = -1;
    first_hs    = -1;
    last_hs     = -1;
    hs_cnt      = 0;
  endtask

  // One clock: check DUT against the model at the negedge, then advance the model.
  task automatic tick();
    logic  flush_s;
    beat_t in_s;
    beat_t popped;
    if (rnd_ready) out_tready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("in_tready", 192'(in_tready), 192'((exp_q.size() < DEPTH) && !flush));
    chk("fill_lvl", 192'(fill_lvl), 192'(exp_q.size()));
    chk("pkt_cnt", 192'(pkt_cnt), 192'(m_pkts));
    chk("ovf_err", 192'(ovf_err), 192'(m_ovf));
    if (m_pkts == 0) chk("valid_without_pkt", 192'(out_tvalid), 192'(0));
    if (prev_hold) begin
      chk("hold_valid", 192'(out_tvalid), 192'(1));
      chk("hold_data", 192'(out_b), 192'(prev_beat));
    end
    if (prev_mid) chk("bubble_in_pkt", 192'(out_tvalid), 192'(1));
    if (out_tvalid && exp_q.size() > 0) chk("out_beat", 192'(out_b), 192'(exp_q[0]));
    wr        = in_tvalid & in_tready;
    rd        = out_tvalid & out_tready;
    flush_s   = flush;
    in_s      = in_b;
    prev_hold = out_tvalid & ~out_tready & ~flush_s;
    prev_mid  = rd & ~out_tlast & ~flush_s;
    prev_beat = out_b;
    if (out_tvalid && first_valid < 0) first_valid = tick_no;
    if (wr && in_tlast) last_wr = tick_no;
    if (rd) begin
      if (first_hs < 0) first_hs = tick_no;
      last_hs = tick_no;
      hs_cnt++;
    end
    @(posedge clk);
    if (flush_s) begin
      exp_q.delete();
      m_pkts = 0;
      m_ovf  = 1'b0;
    end else begin
      if (exp_q.size() == DEPTH && m_pkts == 0) m_ovf = 1'b1;
      if (rd && exp_q.size() > 0) begin
        popped = exp_q.pop_front();
        if (popped.l) m_pkts--;
      end
      if (wr) begin
        exp_q.push_back(in_s);
        if (in_s.l) m_pkts++;
      end
    end
    tick_no++;
    #1;
  endtask

  task automatic rand_beat(input logic last);
    in_tdata = {$urandom, $urandom, $urandom, $urandom};
    in_tkeep = 16'($urandom);
    in_tuser = 16'($urandom);
    in_tlast = last;
  endtask

  task automatic drive_beat(input logic last);
    in_tvalid = 1'b1;
    rand_beat(last);
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (wr) break;
    end
    if (!wr) chk("accept_timeout", 192'(in_tready), 192'(1));
  endtask

  task automatic send_packet(input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      drive_beat(i == len - 1);
      if (gap != 0 && (i % gap) == gap - 1 && i != len - 1) begin
        in_tvalid = 1'b0;
        tick();
      end
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic drain(input int limit);
    in_tvalid = 1'b0;
    for (int n = 0; n < limit; n++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_fill", 192'(fill_lvl), 192'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, pmin, pmax, len, gap;
    rst_n = 1'b0; flush = 1'b0; in_tvalid = 1'b0; out_tready = 1'b0; rnd_ready = 1'b0;
    prev_hold = 1'b0; prev_mid = 1'b0; prev_beat = '0;
    rand_beat(1'b0);
    reset_stats();

    repeat (3) @(negedge clk);
    chk("rst_tvalid", 192'(out_tvalid), 192'(0));
    chk("rst_fill", 192'(fill_lvl), 192'(0));
    chk("rst_pkt", 192'(pkt_cnt), 192'(0));
    chk("rst_ovf", 192'(ovf_err), 192'(0));
    chk("rst_tdata", 192'(out_tdata), 192'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("rst_rel_tready", 192'(in_tready), 192'(1));

    // 1: single 256-beat packet, continuous source and sink
    out_tready = 1'b1;
    reset_stats();
    send_packet(256, 0);
    drain(1000);
    chk("t1_latency", 192'(first_valid - last_wr), 192'(2));
    chk("t1_span", 192'(last_hs - first_hs + 1), 192'(256));
    chk("t1_count", 192'(hs_cnt), 192'(256));

    // 2: source gaps every 4 beats, output burst contiguous
    reset_stats();
    send_packet(64, 4);
    drain(1000);
    chk("t2_span", 192'(last_hs - first_hs + 1), 192'(64));

    // 3: sink stalled while two full packets are written
    out_tready = 1'b0;
    reset_stats();
    send_packet(256, 0);
    send_packet(256, 0);
    in_tvalid = 1'b1;
    rand_beat(1'b1);
    repeat (3) tick();
    chk("t3_fill", 192'(fill_lvl), 192'(DEPTH));
    chk("t3_pkts", 192'(pkt_cnt), 192'(2));
    chk("t3_tready", 192'(in_tready), 192'(0));
    out_tready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (wr) break;
    end
    if (!wr) chk("t3_accept", 192'(in_tready), 192'(1));
    drain(2000);
    chk("t3_count", 192'(hs_cnt), 192'(513));

    // 4: back-to-back 2-beat packets, tlast in and out in the same cycle
    reset_stats();
    out_tready = 1'b0;
    pmin = 1 << 20;
    pmax = -1;
    for (int i = 0; i < 80; i++) begin
      in_tvalid  = 1'b1;
      rand_beat(i[0]);
      out_tready = (i >= 4);
      tick();
      if (!wr) chk("t4_accept", 192'(in_tready), 192'(1));
      if (i >= 12 && i <= 70) begin
        if (int'(pkt_cnt) < pmin) pmin = int'(pkt_cnt);
        if (int'(pkt_cnt) > pmax) pmax = int'(pkt_cnt);
      end
    end
    out_tready = 1'b1;
    drain(500);
    chk("t4_pkt_const", 192'(pmax), 192'(pmin));
    chk("t4_span", 192'(last_hs - first_hs + 1), 192'(80));

    // 5: oversize packet deadlocks and latches overflow until flushed
    acc = 0;
    for (int i = 0; i < 520; i++) begin
      in_tvalid = 1'b1;
      rand_beat(1'b0);
      tick();
      if (wr) acc++;
    end
    chk("t5_accepted", 192'(acc), 192'(DEPTH));
    chk("t5_ovf", 192'(ovf_err), 192'(1));
    chk("t5_tvalid", 192'(out_tvalid), 192'(0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_tvalid = 1'b0;
    chk("t5_ovf_clr", 192'(ovf_err), 192'(0));
    chk("t5_fill_clr", 192'(fill_lvl), 192'(0));
    tick();

    // 6: flush with a partial packet in and a packet half sent
    out_tready = 1'b0;
    send_packet(200, 0);
    repeat (2) tick();
    out_tready = 1'b1;
    for (int i = 0; i < 100; i++) drive_beat(1'b0);
    in_tvalid = 1'b1;
    rand_beat(1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_tvalid = 1'b0;
    chk("t6_tvalid", 192'(out_tvalid), 192'(0));
    chk("t6_fill", 192'(fill_lvl), 192'(0));
    chk("t6_pkts", 192'(pkt_cnt), 192'(0));
    reset_stats();
    send_packet(32, 0);
    drain(500);
    chk("t6_count", 192'(hs_cnt), 192'(32));
    chk("t6_span", 192'(last_hs - first_hs + 1), 192'(32));

    // 7: random packet lengths, source gaps and sink stalls
    rnd_ready = 1'b1;
    for (int p = 0; p < 12; p++) begin
      len = int'($urandom_range(1, 40));
      gap = int'($urandom_range(0, 3));
      send_packet(len, gap);
    end
    drain(3000);
    rnd_ready  = 1'b0;
    out_tready = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
